// File: rtl/wr_fram_buf_core.sv
// wr_fram_buf_core: 32-bit write / 128-bit read line buffer RAM (4 lanes x 1024 entries).
// Define WR_FRAM_BUF_OUTREG_EN to add an output pipeline register (2-cycle read latency).
module wr_fram_buf_core #(
    parameter int WR_DATA_WIDTH = 32,
    parameter int WR_ADDR_WIDTH = 12,
    parameter int RD_DATA_WIDTH = 128,
    parameter int RD_ADDR_WIDTH = 10
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst,
    input  logic                     wr_en,
    input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
    output logic [RD_DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << RD_ADDR_WIDTH;
    logic [RD_DATA_WIDTH-1:0] ram_q;
    // One RAM per lane; the low write-address bits pick the lane so word 4R+k lands in bits 32k+.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [WR_DATA_WIDTH-1:0] ram [DEPTH];
        logic [WR_DATA_WIDTH-1:0] q;
        always_ff @(posedge wr_clk) begin
            if (!wr_rst && wr_en && wr_addr[1:0] == 2'(i)) ram[wr_addr[WR_ADDR_WIDTH-1:2]] <= wr_data;
            q <= wr_rst ? '0 : ram[rd_addr];
        end
        assign ram_q[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] = q;
    end
`ifdef WR_FRAM_BUF_OUTREG_EN
    always_ff @(posedge wr_clk) rd_data <= wr_rst ? '0 : ram_q;
`else
    assign rd_data = ram_q;
`endif
endmodule

// File: tb/tb_wr_fram_buf_core.sv
// tb_wr_fram_buf_core: directed self-checking bench for wr_fram_buf_core.
module tb_wr_fram_buf_core;
`ifdef WR_FRAM_BUF_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic         wr_clk = 1'b0;
    logic         wr_rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [11:0]  wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic [9:0]   rd_addr = '0;
    logic [127:0] rd_data;
    int n_chk = 0;
    int n_fail = 0;

    wr_fram_buf_core dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic logic [31:0] sw(input int k);
        return (32'(k) * 32'h9E3779B9) ^ 32'hA5A50000;
    endfunction

    // Inputs change just after a falling edge; one rising edge consumes them.
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge wr_clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [9:0] r);
        rd_addr = r;
        repeat (LAT) @(negedge wr_clk);
    endtask

    task automatic test_reset();
        wr_rst = 1'b1;
        repeat (2) @(negedge wr_clk);
        n_chk++;
        if (rd_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", rd_data, 128'h0);
        end
        wr_rst = 1'b0;
    endtask

    task automatic test_width_conv();
        wr(12'd0, 32'h11111111);
        wr(12'd1, 32'h22222222);
        wr(12'd2, 32'h33333333);
        wr(12'd3, 32'h44444444);
        wr(12'd4, 32'h01020304);
        wr(12'd5, 32'h05060708);
        wr(12'd6, 32'h090A0B0C);
        wr(12'd7, 32'h0D0E0F10);
        rd(10'd0);
        n_chk++;
        if (rd_data !== 128'h44444444_33333333_22222222_11111111) begin
            n_fail++;
            $display("FAIL width_beat0: got %h expected %h", rd_data, 128'h44444444_33333333_22222222_11111111);
        end
        rd(10'd1);
        n_chk++;
        if (rd_data !== 128'h0D0E0F10_090A0B0C_05060708_01020304) begin
            n_fail++;
            $display("FAIL width_beat1: got %h expected %h", rd_data, 128'h0D0E0F10_090A0B0C_05060708_01020304);
        end
    endtask

    task automatic test_top_boundary();
        wr(12'd4093, 32'h12345678);
        wr(12'd4094, 32'h9ABCDEF0);
        wr(12'd4092, 32'h00000000);
        wr(12'd4095, 32'h00000000);
        rd(10'd1023);
        n_chk++;
        if (rd_data !== 128'h00000000_9ABCDEF0_12345678_00000000) begin
            n_fail++;
            $display("FAIL top_prefill: got %h expected %h", rd_data, 128'h00000000_9ABCDEF0_12345678_00000000);
        end
        wr(12'd4095, 32'hDEADBEEF);
        wr(12'd4092, 32'hCAFEF00D);
        rd(10'd1023);
        n_chk++;
        if (rd_data !== 128'hDEADBEEF_9ABCDEF0_12345678_CAFEF00D) begin
            n_fail++;
            $display("FAIL top_beat1023: got %h expected %h", rd_data, 128'hDEADBEEF_9ABCDEF0_12345678_CAFEF00D);
        end
        rd(10'd0);
        n_chk++;
        if (rd_data !== 128'h44444444_33333333_22222222_11111111) begin
            n_fail++;
            $display("FAIL top_no_alias: got %h expected %h", rd_data, 128'h44444444_33333333_22222222_11111111);
        end
    endtask

    task automatic test_collision();
        for (int a = 20; a < 24; a++) wr(12'(a), 32'h0);
        wr_en = 1'b1;
        wr_addr = 12'd21;
        wr_data = 32'hAAAA5555;
        rd_addr = 10'd5;
        @(negedge wr_clk);
        wr_en = 1'b0;
        repeat (LAT - 1) @(negedge wr_clk);
        n_chk++;
        if (rd_data !== 128'h0) begin
            n_fail++;
            $display("FAIL collision_old: got %h expected %h", rd_data, 128'h0);
        end
        @(negedge wr_clk);
        n_chk++;
        if (rd_data !== 128'h00000000_00000000_AAAA5555_00000000) begin
            n_fail++;
            $display("FAIL collision_new: got %h expected %h", rd_data, 128'h00000000_00000000_AAAA5555_00000000);
        end
    endtask

    task automatic test_reset_midstream();
        rd_addr = 10'd1;
        @(negedge wr_clk);
        wr_rst = 1'b1;
        wr_en = 1'b1;
        wr_addr = 12'd0;
        wr_data = 32'hFFFFFFFF;
        rd_addr = 10'd0;
        for (int c = 0; c < 2; c++) begin
            @(negedge wr_clk);
            n_chk++;
            if (rd_data !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_hold_%0d: got %h expected %h", c, rd_data, 128'h0);
            end
        end
        wr_rst = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            @(negedge wr_clk);
            n_chk++;
            if (rd_data !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_release_%0d: got %h expected %h", c, rd_data, 128'h0);
            end
        end
        @(negedge wr_clk);
        n_chk++;
        if (rd_data !== 128'h44444444_33333333_22222222_11111111) begin
            n_fail++;
            $display("FAIL reset_retains: got %h expected %h", rd_data, 128'h44444444_33333333_22222222_11111111);
        end
    endtask

    // One word written per cycle; beat b is issued two cycles after its last word lands.
    task automatic test_streaming();
        int i;
        int b;
        logic [127:0] exp;
        for (int j = 0; j <= 642 + LAT; j++) begin
            i = j - LAT;
            if (i >= 5 && (i - 5) % 4 == 0 && (i - 5) / 4 < 160) begin
                b = (i - 5) / 4;
                exp = {sw(4*b+3), sw(4*b+2), sw(4*b+1), sw(4*b)};
                n_chk++;
                if (rd_data !== exp) begin
                    n_fail++;
                    $display("FAIL stream_beat%0d: got %h expected %h", b, rd_data, exp);
                end
            end
            wr_en = j < 640;
            wr_addr = 12'(j);
            wr_data = sw(j);
            if (j >= 5 && (j - 5) % 4 == 0 && (j - 5) / 4 < 160) rd_addr = 10'((j - 5) / 4);
            @(negedge wr_clk);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        @(negedge wr_clk);
        test_reset();
        test_width_conv();
        test_top_boundary();
        test_collision();
        test_reset_midstream();
        test_streaming();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
